// File: rtl/request_queue_pkg.sv
// request_queue_pkg -- shared constants and types for the request queue.
//   NO_REQ      : reserved code meaning "no request" (never stored)
//   DEF_DATA_W  : default request-code width
//   DEF_DEPTH   : default number of queue slots
//   op_e        : decoded operation for one cycle
package request_queue_pkg;

  localparam int unsigned NO_REQ     = 0;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_POPPUSH,
    OP_INS,
    OP_CONFLICT
  } op_e;

endpackage

// File: rtl/request_queue_param.sv
// request_queue_param -- shifting request queue with tail push, head pop,
// indexed insert, optional duplicate suppression and registered random read.
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   push       : append push_data at the tail
//   push_data  : code to append (0 is rejected)
//   pop        : remove head; remaining entries shift toward the head
//   ins        : insert ins_data at slot ins_idx (clamped to the tail)
//   ins_idx    : insertion slot
//   ins_data   : code to insert (0 is rejected)
//   rd_idx     : random-read index, registered every cycle
//   rd_data    : slot contents at the registered read index
//   head       : slot 0 contents
//   count      : number of valid entries
//   empty/full : count == 0 / count == DEPTH
//   dup        : one-cycle pulse, push/ins dropped as a duplicate
//   err        : one-cycle pulse, an operation was rejected
module request_queue_param
  import request_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DEDUP  = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         ins,
  input  logic [$clog2(DEPTH)-1:0]     ins_idx,
  input  logic [DATA_W-1:0]            ins_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         dup,
  output logic                         err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] NO_CODE = DATA_W'(NO_REQ);

  logic [DEPTH-1:0][DATA_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [IDX_W-1:0]             rd_idx_q;
  logic                         dup_q, dup_d;
  logic                         err_q, err_d;

  op_e                          op;
  logic                         pop_eff, app_eff, ins_eff;
  logic [CNT_W-1:0]             ins_pos, app_pos;
  logic [DEPTH-1:0]             push_hit_v, ins_hit_v;
  logic                         push_hit, ins_hit;

  always_comb begin
    if (ins)
      op = (push || pop) ? OP_CONFLICT : OP_INS;
    else if (push && pop)
      op = OP_POPPUSH;
    else if (push)
      op = OP_PUSH;
    else if (pop)
      op = OP_POP;
    else
      op = OP_IDLE;
  end

  // A pop on an empty queue is simply dropped when paired with a push.
  assign pop_eff = pop && !ins && !empty;

  // When a pop retires the head in the same cycle, the new tail is one lower.
  assign app_pos = pop_eff ? (count_q - CNT_W'(1)) : count_q;
  assign ins_pos = (CNT_W'(ins_idx) >= count_q) ? count_q : CNT_W'(ins_idx);

  // Duplicate detection over valid slots; the head being popped does not count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign push_hit_v[i] = (CNT_W'(i) < count_q) && (slot_q[i] == push_data)
                           && ((i != 0) || !pop_eff);
    assign ins_hit_v[i]  = (CNT_W'(i) < count_q) && (slot_q[i] == ins_data);
  end

  assign push_hit = (DEDUP != 0) && (|push_hit_v);
  assign ins_hit  = (DEDUP != 0) && (|ins_hit_v);

  always_comb begin
    app_eff = 1'b0;
    ins_eff = 1'b0;
    dup_d   = 1'b0;
    err_d   = 1'b0;
    unique case (op)
      OP_CONFLICT: err_d = 1'b1;
      OP_INS: begin
        if (ins_data == NO_CODE || full) err_d = 1'b1;
        else if (ins_hit)                dup_d = 1'b1;
        else                             ins_eff = 1'b1;
      end
      OP_POP: begin
        if (empty) err_d = 1'b1;
      end
      OP_PUSH, OP_POPPUSH: begin
        if (push_data == NO_CODE || (full && !pop_eff)) err_d = 1'b1;
        else if (push_hit)                               dup_d = 1'b1;
        else                                             app_eff = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-slot next value: hold, shift toward head, shift toward tail, or load.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [DATA_W-1:0] above, below, nxt;

    if (i == DEPTH-1) begin : g_last
      assign above = '0;
    end else begin : g_mid
      assign above = slot_q[i+1];
    end

    if (i == 0) begin : g_first
      assign below = '0;
    end else begin : g_rest
      assign below = slot_q[i-1];
    end

    always_comb begin
      nxt = slot_q[i];
      if (ins_eff) begin
        if (CNT_W'(i) == ins_pos)     nxt = ins_data;
        else if (CNT_W'(i) > ins_pos) nxt = below;
      end else begin
        if (pop_eff) nxt = above;
        if (app_eff && (CNT_W'(i) == app_pos)) nxt = push_data;
      end
    end

    assign slot_d[i] = nxt;
  end

  always_comb begin
    count_d = count_q;
    if (ins_eff || (app_eff && !pop_eff)) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (pop_eff && !app_eff) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q   <= '0;
      count_q  <= '0;
      rd_idx_q <= '0;
      dup_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx;
      dup_q    <= dup_d;
      err_q    <= err_d;
    end
  end

  assign head    = slot_q[0];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_MAX);
  assign dup     = dup_q;
  assign err     = err_q;
  assign rd_data = (32'(rd_idx_q) < DEPTH) ? slot_q[rd_idx_q] : '0;

endmodule

// File: tb/tb_request_queue_param.sv
// tb_request_queue_param -- drives a 16-deep and a 4-deep queue with the same
// stimulus and compares every output against a queue-based reference model.
module tb_request_queue_param;

  typedef int unsigned q_t[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic       push, pop, ins;
  logic [3:0] push_data, ins_data, ins_idx, rd_idx;

  logic [3:0] rd_data_a, head_a;
  logic [4:0] count_a;
  logic       empty_a, full_a, dup_a, err_a;

  logic [3:0] rd_data_b, head_b;
  logic [2:0] count_b;
  logic       empty_b, full_b, dup_b, err_b;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  q_t          qa, qb;
  bit          exp_dup_a, exp_err_a, exp_dup_b, exp_err_b;
  int unsigned exp_rd_a, exp_rd_b;

  always #5 clk = ~clk;

  request_queue_param #(.DATA_W(4), .DEPTH(16), .DEDUP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data),
    .pop(pop), .ins(ins), .ins_idx(ins_idx), .ins_data(ins_data),
    .rd_idx(rd_idx), .rd_data(rd_data_a), .head(head_a), .count(count_a),
    .empty(empty_a), .full(full_a), .dup(dup_a), .err(err_a)
  );

  request_queue_param #(.DATA_W(4), .DEPTH(4), .DEDUP(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data),
    .pop(pop), .ins(ins), .ins_idx(ins_idx[1:0]), .ins_data(ins_data),
    .rd_idx(rd_idx[1:0]), .rd_data(rd_data_b), .head(head_b), .count(count_b),
    .empty(empty_b), .full(full_b), .dup(dup_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit holds(input q_t q, input int unsigned v);
    foreach (q[k]) if (q[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned slot_of(input q_t q, input int unsigned idx);
    return (idx < q.size()) ? q[idx] : 0;
  endfunction

  // Reference behaviour: pop first, then push against what remains.
  function automatic void model_step(inout q_t q, input int unsigned depth,
                                     input bit ps, input int unsigned pd,
                                     input bit pp, input bit in,
                                     input int unsigned ii, input int unsigned id,
                                     output bit d, output bit e);
    int pos;
    d = 1'b0;
    e = 1'b0;
    if (in) begin
      if (ps || pp)                        e = 1'b1;
      else if (id == 0 || q.size() >= depth) e = 1'b1;
      else if (holds(q, id))               d = 1'b1;
      else begin
        pos = (ii >= q.size()) ? q.size() : int'(ii);
        q.insert(pos, id);
      end
    end else begin
      if (pp) begin
        if (q.size() > 0) void'(q.pop_front());
        else if (!ps)     e = 1'b1;
      end
      if (ps) begin
        if (pd == 0 || q.size() >= depth) e = 1'b1;
        else if (holds(q, pd))            d = 1'b1;
        else                              q.push_back(pd);
      end
    end
  endfunction

  task automatic check_all();
    check_eq("a_head",  head_a,    slot_of(qa, 0));
    check_eq("a_count", count_a,   qa.size());
    check_eq("a_empty", empty_a,   int'(qa.size() == 0));
    check_eq("a_full",  full_a,    int'(qa.size() == 16));
    check_eq("a_dup",   dup_a,     exp_dup_a);
    check_eq("a_err",   err_a,     exp_err_a);
    check_eq("a_rd",    rd_data_a, slot_of(qa, exp_rd_a));
    check_eq("b_head",  head_b,    slot_of(qb, 0));
    check_eq("b_count", count_b,   qb.size());
    check_eq("b_empty", empty_b,   int'(qb.size() == 0));
    check_eq("b_full",  full_b,    int'(qb.size() == 4));
    check_eq("b_dup",   dup_b,     exp_dup_b);
    check_eq("b_err",   err_b,     exp_err_b);
    check_eq("b_rd",    rd_data_b, slot_of(qb, exp_rd_b));
  endtask

  task automatic step(input bit ps, input int unsigned pd, input bit pp,
                      input bit in, input int unsigned ii, input int unsigned id,
                      input int unsigned ri);
    push      = ps;
    push_data = 4'(pd);
    pop       = pp;
    ins       = in;
    ins_idx   = 4'(ii);
    ins_data  = 4'(id);
    rd_idx    = 4'(ri);
    @(posedge clk);
    model_step(qa, 16, ps, pd, pp, in, ii, id, exp_dup_a, exp_err_a);
    model_step(qb, 4, ps, pd, pp, in, ii % 4, id, exp_dup_b, exp_err_b);
    exp_rd_a = ri;
    exp_rd_b = ri % 4;
    #1;
    check_all();
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    exp_dup_a = 1'b0; exp_err_a = 1'b0; exp_rd_a = 0;
    exp_dup_b = 1'b0; exp_err_b = 1'b0; exp_rd_b = 0;
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; ins = 1'b0;
    push_data = '0; ins_data = '0; ins_idx = '0; rd_idx = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    clear_model();
    check_all();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    clear_model();
    apply_reset();

    // push 3,5,7 then registered read of slot 2
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2);
    check_eq("r033_count", count_a, 3);
    check_eq("r033_head", head_a, 3);
    check_eq("r033_rd", rd_data_a, 7);

    // insert 9 at slot 1, then pop
    step(0, 0, 0, 1, 1, 9, 1);
    check_eq("r034_count", count_a, 4);
    check_eq("r034_slot1", rd_data_a, 9);
    step(0, 0, 1, 0, 0, 0, 0);
    check_eq("r034_head", head_a, 9);

    // duplicate and zero push
    apply_reset();
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    check_eq("r035_dup", dup_a, 1);
    check_eq("r035_count", count_a, 2);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("r035_err", err_a, 1);
    check_eq("r035_dup0", dup_a, 0);

    // 4-deep instance: full, reject, pop+push while full
    apply_reset();
    for (int unsigned v = 1; v <= 4; v++) step(1, v, 0, 0, 0, 0, 0);
    check_eq("r036_full", full_b, 1);
    step(1, 6, 0, 0, 0, 0, 0);
    check_eq("r036_err", err_b, 1);
    step(1, 6, 1, 0, 0, 0, 3);
    check_eq("r036_head", head_b, 2);
    check_eq("r036_full2", full_b, 1);
    step(0, 0, 0, 0, 0, 0, 3);
    check_eq("r036_tail", rd_data_b, 6);

    // empty pop, then ins+pop conflict
    apply_reset();
    step(0, 0, 1, 0, 0, 0, 0);
    check_eq("r037_err", err_a, 1);
    check_eq("r037_count", count_a, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 8, 0);
    check_eq("r037_conflict", err_a, 1);
    check_eq("r037_head", head_a, 3);

    // randomized traffic
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 50, $urandom_range(0, 15),
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // asynchronous reset mid-stream with five entries queued
    apply_reset();
    for (int unsigned v = 1; v <= 5; v++) step(1, v, 0, 0, 0, 0, 4);
    check_eq("r038_pre", count_a, 5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    clear_model();
    check_all();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("r030_empty", empty_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
